des_key_schedule: RTL and testbench
===================================

// Module: des_key_schedule
// PURPOSE
//  Parametrised DES key-schedule engine. Takes a 64-bit key and applies PC-1 to form C0/D0.
//  Then streams the round subkeys K1..KN (encrypt) or KN..K1 (decrypt), one per handshake.
//  Each subkey is produced by rotating C/D and applying PC-2, and is 48 bits wide.
//  Sits between the key register file and the DES round datapath; replaces static PC-1 use.
// PARAMETERS
//  NUM_ROUNDS  16  rounds emitted, 1..16; values <16 only for reduced-round test builds
//  OUT_REG     1   1: subkey/subkey_valid/round_idx registered (+1 cycle latency); 0: from C/D regs
// PORTS
//  clk           in   1   single clock, rising edge
//  rst_n         in   1   synchronous, active-low reset
//  start         in   1   1-cycle request; accepted only when busy==0
//  decrypt       in   1   sampled with start: 0=K1 first, 1=K(NUM_ROUNDS) first
//  key_in        in   64  key; key_in[n] = DES key bit n (n=1..63); parity bits 8,16..56 and bit 0 ignored
//  subkey_ready  in   1   consumer accepts subkey this cycle
//  subkey_valid  out  1   subkey/round_idx valid
//  subkey        out  48  PC-2 output, subkey[47] = PC-2 bit 1
//  round_idx     out  4   round number 0..NUM_ROUNDS-1 of the subkey presented (K(round_idx+1))
//  busy          out  1   job accepted and not yet completed
//  done          out  1   1-cycle pulse the cycle after the last subkey handshake
// BEHAVIOUR
//  Reset:
//  - All outputs are 0.
//  - C/D and the round counter are cleared and the FSM goes to IDLE.
//  - A reset asserted mid-job aborts the job; no done pulse is produced.
//  FSM:
//  - IDLE: on start, load {C,D} = PC1(key_in), latch decrypt, set busy, go to ROT.
//  - ROT: compute this round's C/D rotation and go to OUT.
//    Encrypt round r (1-based): rotate C and D left by SHIFT[r].
//    Decrypt: the first round uses no rotation (C16D16==C0D0); round r>1 rotates right by SHIFT[18-r].
//    Reduced NUM_ROUNDS in decrypt: on load, first pre-rotate left by the sum of SHIFT[1..NUM_ROUNDS].
//    This pre-rotate takes one extra cycle in ROT.
//  - OUT: present PC2({C,D}) with subkey_valid=1.
//    Hold subkey, round_idx and valid stable while subkey_ready==0. No drop, no duplicate.
//    On handshake: if last round, go to DONE; else go to ROT.
//  - DONE: pulse done, clear busy, return to IDLE.
//  - Back-to-back: a start in the same cycle as done is ignored; a start is accepted from the next cycle.
//  SHIFT[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. Rotations are mod 28 and independent on C (pc1[55:28]) and D (pc1[27:0]).
//  Latency with ready tied high:
//  - start at cycle t: first subkey_valid at t+2 (+1 if OUT_REG, +1 if decrypt pre-rotate).
//  - Subsequent subkeys every 2 cycles.
//  Ignored inputs:
//  - start while busy is ignored.
//  - key_in/decrypt changes after acceptance have no effect on the job in flight.
//  - round_idx counts up in encrypt and down in decrypt, so it always names the true round of the subkey.
// STRUCTURE
//  des_pkg holds: the PC1_TABLE[56] and PC2_TABLE[48] index constants, the SHIFT_SCHED[16] constant,
//  and the FSM state enum (IDLE, ROT, OUT, DONE).
//  Sub-module des_pc2: combinational 56->48 PC-2 permutation driven from des_pkg tables.
//  PC-1 is applied inline at load from PC1_TABLE.
// TESTING
//  Std key 64'h133457799BBCDFF1 maps to key_in[n] = std[(64-n)%64].
//  1) That key, encrypt, ready=1 -> K1=48'h1B02EFFC7072, K16=48'hCB3D8B0E17F5, 16 valids, one done.
//  2) Same key, decrypt -> first subkey 48'hCB3D8B0E17F5 with round_idx=15.
//     Last subkey 48'h1B02EFFC7072 with round_idx=0.
//  3) Encrypt with ready toggling randomly (and 10-cycle low on K5) -> 16 unique subkeys in order.
//     Subkey and round_idx are stable throughout every stall.
//  4) start pulsed while busy, and in the done cycle -> ignored; outputs match scenario 1 unchanged.
//  5) rst_n=0 during round 7 -> next cycle all outputs 0, no done pulse.
//     A new start then yields K1 correctly.
//  6) NUM_ROUNDS=4 build, decrypt -> K4,K3,K2,K1 of the std key, matching the scenario-1 K1..K4.

Source files
------------

// File: rtl/des_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : des_pkg
//  Description : Shared DES key-schedule constants: PC-1 and PC-2 selection
//                tables (1-based DES bit numbers), per-round left-shift
//                schedule, FSM state encoding and rotation helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package des_pkg;

    // PC-1: entry i gives the DES key bit (1..64, bit 1 = MSB) that lands in
    // PC-1 output bit i+1.
    localparam logic [5:0] PC1_TABLE [56] = '{
        6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,
        6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
        6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27,
        6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
        6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15,
        6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
        6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29,
        6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
    };

    // PC-2: entry i gives the C/D bit (1..56, bit 1 = C MSB) that lands in
    // subkey bit i+1.
    localparam logic [5:0] PC2_TABLE [48] = '{
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
        6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
        6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
        6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
        6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
        6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
        6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    // Left-rotation amount for rounds 1..16 (index 0 = round 1).
    localparam logic [1:0] SHIFT_SCHED [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        OUT  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Bit 27 is DES bit 1, so a DES "left shift" moves bits toward the MSB.
    function automatic logic [27:0] rotl28(input logic [27:0] c, input logic [4:0] s);
        logic [55:0] t;
        t = {c, c} << s;
        return t[55:28];
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] c, input logic [4:0] s);
        logic [55:0] t;
        t = {c, c} >> s;
        return t[27:0];
    endfunction

    // Total left rotation after n rounds, folded mod 28 (zero for n = 16).
    function automatic logic [4:0] pre_shift(input int n);
        int s;
        s = 0;
        for (int i = 0; i < 16; i++) begin
            if (i < n) s += int'(SHIFT_SCHED[i]);
        end
        return 5'(s % 28);
    endfunction

endpackage
`default_nettype wire

// File: rtl/des_pc2.sv
`default_nettype none
// ============================================================================
//  Module      : des_pc2
//  Description : Combinational PC-2 compression permutation, 56 -> 48 bits.
//  Ports       : cd     in  56  {C,D}, cd[55] = C/D bit 1
//                subkey out 48  subkey[47] = PC-2 output bit 1
//  Revision    : 1.0 - initial release
// ============================================================================
module des_pc2
    import des_pkg::*;
(
    input  logic [55:0] cd,
    output logic [47:0] subkey
);

    for (genvar g = 0; g < 48; g++) begin : g_pc2
        assign subkey[47-g] = cd[6'd56 - PC2_TABLE[g]];
    end

    // C/D bits 9,18,22,25,35,38,43,54 are dropped by PC-2.
    logic w_unused_cd;
    assign w_unused_cd = ^{cd[47], cd[38], cd[34], cd[31], cd[21], cd[18], cd[13], cd[2]};

endmodule
`default_nettype wire

// File: rtl/des_key_schedule.sv
`default_nettype none
// ============================================================================
//  Module      : des_key_schedule
//  Description : DES key-schedule engine. Loads PC1(key_in) into C/D on
//                start, then streams round subkeys K1..KN (encrypt) or
//                KN..K1 (decrypt) over a valid/ready handshake.
//  Parameters  : NUM_ROUNDS  rounds emitted (1..16)
//                OUT_REG     1: registered subkey outputs, 0: direct from C/D
//  Ports       : clk, rst_n (sync, active low)
//                start, decrypt, key_in[63:0]   job request
//                subkey_ready                   consumer accept
//                subkey_valid, subkey[47:0], round_idx[3:0]  subkey stream
//                busy, done                     job status
//  Revision    : 1.0 - initial release
// ============================================================================
module des_key_schedule
    import des_pkg::*;
#(
    parameter int NUM_ROUNDS = 16,
    parameter bit OUT_REG    = 1'b1
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        decrypt,
    input  logic [63:0] key_in,
    input  logic        subkey_ready,
    output logic        subkey_valid,
    output logic [47:0] subkey,
    output logic [3:0]  round_idx,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] PRE_SHIFT = pre_shift(NUM_ROUNDS);
    localparam bit         NEED_PRE  = (NUM_ROUNDS < 16);
    localparam logic [3:0] LAST_IDX  = 4'(NUM_ROUNDS - 1);

    state_t      r_state;
    logic [55:0] r_cd;
    logic [3:0]  r_rnd;      // 0-based round of the subkey C/D currently holds
    logic        r_dec;
    logic        r_first;
    logic        r_pre;
    logic        r_busy;
    logic        r_done;

    logic [55:0] w_pc1;
    logic [47:0] w_pc2;
    logic [55:0] w_cd_rot;
    logic [3:0]  w_undo_idx;
    logic        w_last;
    logic        w_hs;

    // key_in[n] is DES key bit n; PC-1 never selects the parity bits.
    for (genvar g = 0; g < 56; g++) begin : g_pc1
        assign w_pc1[55-g] = key_in[PC1_TABLE[g]];
    end

    logic w_unused_parity;
    assign w_unused_parity = ^{key_in[0], key_in[8], key_in[16], key_in[24],
                               key_in[32], key_in[40], key_in[48], key_in[56]};

    des_pc2 u_pc2 (
        .cd     (r_cd),
        .subkey (w_pc2)
    );

    // In decrypt, stepping back from K(j+2) to K(j+1) undoes round j+2's
    // left shift; r_rnd already holds j at that point.
    assign w_undo_idx = r_rnd + 4'd1;
    assign w_last     = r_dec ? (r_rnd == 4'd0) : (r_rnd == LAST_IDX);
    assign w_hs       = subkey_valid & subkey_ready;

    always_comb begin
        w_cd_rot = r_cd;
        if (!r_dec) begin
            w_cd_rot = {rotl28(r_cd[55:28], {3'b000, SHIFT_SCHED[r_rnd]}),
                        rotl28(r_cd[27:0],  {3'b000, SHIFT_SCHED[r_rnd]})};
        end else if (r_pre) begin
            w_cd_rot = {rotl28(r_cd[55:28], PRE_SHIFT),
                        rotl28(r_cd[27:0],  PRE_SHIFT)};
        end else if (!r_first) begin
            w_cd_rot = {rotr28(r_cd[55:28], {3'b000, SHIFT_SCHED[w_undo_idx]}),
                        rotr28(r_cd[27:0],  {3'b000, SHIFT_SCHED[w_undo_idx]})};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cd    <= '0;
            r_rnd   <= '0;
            r_dec   <= 1'b0;
            r_first <= 1'b0;
            r_pre   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_cd    <= w_pc1;
                        r_dec   <= decrypt;
                        r_rnd   <= decrypt ? LAST_IDX : 4'd0;
                        r_first <= 1'b1;
                        r_pre   <= decrypt & NEED_PRE;
                        r_busy  <= 1'b1;
                        r_state <= ROT;
                    end
                end
                ROT: begin
                    r_cd <= w_cd_rot;
                    if (r_dec && r_pre) begin
                        // Extra ROT cycle: C/D now jump forward to C_N/D_N.
                        r_pre <= 1'b0;
                    end else begin
                        r_first <= 1'b0;
                        r_state <= OUT;
                    end
                end
                OUT: begin
                    if (w_hs) begin
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_rnd   <= r_dec ? (r_rnd - 4'd1) : (r_rnd + 4'd1);
                            r_state <= ROT;
                        end
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;

    if (OUT_REG) begin : g_out_reg
        logic        r_sk_valid;
        logic [47:0] r_subkey;
        logic [3:0]  r_idx;

        // Valid drops in the same edge as the accepting handshake so a
        // subkey is never presented twice.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_sk_valid <= 1'b0;
                r_subkey   <= '0;
                r_idx      <= '0;
            end else begin
                r_sk_valid <= (r_state == OUT) && !w_hs;
                if (r_state == OUT) begin
                    r_subkey <= w_pc2;
                    r_idx    <= r_rnd;
                end
            end
        end

        assign subkey_valid = r_sk_valid;
        assign subkey       = r_subkey;
        assign round_idx    = r_idx;
    end else begin : g_out_comb
        assign subkey_valid = (r_state == OUT);
        assign subkey       = w_pc2;
        assign round_idx    = r_rnd;
    end

endmodule
`default_nettype wire

// File: tb/tb_des_key_schedule.sv
`default_nettype none
// ============================================================================
//  Module      : tb_des_key_schedule
//  Description : Scoreboard bench for des_key_schedule: a 16-round,
//                registered-output instance and a 4-round, unregistered one.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_des_key_schedule;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start, decrypt, ready;
    logic [63:0] key_in;
    logic        subkey_valid, busy, done;
    logic [47:0] subkey;
    logic [3:0]  round_idx;

    logic        start4, decrypt4, ready4;
    logic [63:0] key_in4;
    logic        subkey_valid4, busy4, done4;
    logic [47:0] subkey4;
    logic [3:0]  round_idx4;

    des_key_schedule #(.NUM_ROUNDS(16), .OUT_REG(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .decrypt(decrypt), .key_in(key_in),
        .subkey_ready(ready), .subkey_valid(subkey_valid), .subkey(subkey),
        .round_idx(round_idx), .busy(busy), .done(done)
    );

    des_key_schedule #(.NUM_ROUNDS(4), .OUT_REG(1'b0)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .decrypt(decrypt4), .key_in(key_in4),
        .subkey_ready(ready4), .subkey_valid(subkey_valid4), .subkey(subkey4),
        .round_idx(round_idx4), .busy(busy4), .done(done4)
    );

    typedef struct packed {
        logic [47:0] sk;
        logic [3:0]  idx;
    } exp_t;

    exp_t q16[$];
    exp_t q4[$];

    // Subkeys K1..K16 of DES key 133457799BBCDFF1.
    logic [47:0] ks [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    int n_checks = 0;
    int n_fail   = 0;
    int done16   = 0;
    int done4c   = 0;
    int rmode    = 0;
    logic [63:0] key_std;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors: every presented subkey is compared to the queue head (so
    // stalled outputs must stay equal to it); a handshake retires the head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done16++;
            if (subkey_valid) begin
                if (q16.size() == 0) begin
                    chk("extra_valid16", {63'd0, subkey_valid}, 64'd0);
                end else begin
                    chk("subkey16", {16'd0, subkey}, {16'd0, q16[0].sk});
                    chk("round_idx16", {60'd0, round_idx}, {60'd0, q16[0].idx});
                    if (ready) void'(q16.pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (done4) done4c++;
            if (subkey_valid4) begin
                if (q4.size() == 0) begin
                    chk("extra_valid4", {63'd0, subkey_valid4}, 64'd0);
                end else begin
                    chk("subkey4", {16'd0, subkey4}, {16'd0, q4[0].sk});
                    chk("round_idx4", {60'd0, round_idx4}, {60'd0, q4[0].idx});
                    if (ready4) void'(q4.pop_front());
                end
            end
        end
    end

    // Ready driver: tied high, or random with one 10-cycle stall on K5.
    initial begin
        int  stall;
        bit  k5;
        stall = 0;
        k5    = 1'b0;
        ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rmode == 0) begin
                ready = 1'b1;
            end else if (stall > 0) begin
                ready = 1'b0;
                stall--;
            end else if (subkey_valid && round_idx == 4'd4 && !k5) begin
                ready = 1'b0;
                stall = 9;
                k5    = 1'b1;
            end else begin
                ready = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic issue16(input bit dec);
        @(posedge clk);
        #1;
        start   = 1'b1;
        decrypt = dec;
        key_in  = key_std;
        for (int i = 0; i < 16; i++) begin
            if (dec) q16.push_back('{sk: ks[15-i], idx: 4'(15 - i)});
            else     q16.push_back('{sk: ks[i],    idx: 4'(i)});
        end
        @(posedge clk);
        #1;
        start   = 1'b0;
        decrypt = ~dec;
        key_in  = ~key_std;
    endtask

    task automatic issue4(input bit dec);
        @(posedge clk);
        #1;
        start4   = 1'b1;
        decrypt4 = dec;
        key_in4  = key_std;
        for (int i = 0; i < 4; i++) begin
            if (dec) q4.push_back('{sk: ks[3-i], idx: 4'(3 - i)});
            else     q4.push_back('{sk: ks[i],   idx: 4'(i)});
        end
        @(posedge clk);
        #1;
        start4   = 1'b0;
        decrypt4 = ~dec;
        key_in4  = 64'h0;
    endtask

    task automatic wait_done16(input int target);
        int c;
        c = 0;
        while (done16 < target && c < 3000) begin
            @(posedge clk);
            c++;
        end
        repeat (10) @(posedge clk);
        chk("done_count16", 64'(done16), 64'(target));
        chk("queue_empty16", 64'(q16.size()), 64'd0);
        chk("busy_idle16", {63'd0, busy}, 64'd0);
    endtask

    task automatic wait_done4(input int target);
        int c;
        c = 0;
        while (done4c < target && c < 1000) begin
            @(posedge clk);
            c++;
        end
        repeat (10) @(posedge clk);
        chk("done_count4", 64'(done4c), 64'(target));
        chk("queue_empty4", 64'(q4.size()), 64'd0);
    endtask

    task automatic wait_round16(input int idx);
        int c;
        c = 0;
        while (!(subkey_valid && round_idx == 4'(idx)) && c < 500) begin
            @(negedge clk);
            c++;
        end
        chk("reach_round16", {63'd0, subkey_valid && round_idx == 4'(idx)}, 64'd1);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_valid"}, {63'd0, subkey_valid}, 64'd0);
        chk({tag, "_subkey"}, {16'd0, subkey}, 64'd0);
        chk({tag, "_round_idx"}, {60'd0, round_idx}, 64'd0);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_done"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        int c;
        logic [63:0] std_key;
        std_key = 64'h133457799BBCDFF1;
        for (int n = 0; n < 64; n++) key_std[n] = std_key[(64 - n) % 64];

        rst_n = 1'b0;
        start = 1'b0; decrypt = 1'b0; key_in = '0;
        start4 = 1'b0; decrypt4 = 1'b0; key_in4 = '0; ready4 = 1'b1;

        // Reset state of both instances.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero_outputs("reset16");
        chk("reset4_valid", {63'd0, subkey_valid4}, 64'd0);
        chk("reset4_subkey", {16'd0, subkey4}, 64'd0);
        chk("reset4_busy", {63'd0, busy4}, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 1) Encrypt, ready high.
        issue16(1'b0);
        wait_done16(1);

        // 2) Decrypt, ready high.
        issue16(1'b1);
        wait_done16(2);

        // 3) Encrypt with random ready and a long stall on K5.
        rmode = 1;
        issue16(1'b0);
        wait_done16(3);
        rmode = 0;

        // 4) Stray starts while busy and in the done cycle.
        issue16(1'b0);
        wait_round16(3);
        @(posedge clk);
        #1;
        start = 1'b1; decrypt = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        c = 0;
        while (!done && c < 500) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("saw_done_pulse", {63'd0, done}, 64'd1);
        start = 1'b1; decrypt = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        chk("done_count_stray", 64'(done16), 64'd4);
        chk("busy_after_stray", {63'd0, busy}, 64'd0);
        chk("queue_after_stray", 64'(q16.size()), 64'd0);

        // 5) Reset during round 7, then a fresh job.
        issue16(1'b0);
        wait_round16(6);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        q16.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_zero_outputs("midjob_reset");
        repeat (40) @(posedge clk);
        chk("no_done_after_abort", 64'(done16), 64'd4);
        issue16(1'b0);
        wait_done16(5);

        // 6) Four-round build: decrypt, then encrypt.
        issue4(1'b1);
        wait_done4(1);
        issue4(1'b0);
        wait_done4(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
